cla_addsub_pipe: RTL
====================

Name: cla_addsub_pipe

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor.
- Built from GROUP-bit lookahead groups (bit P/G, group Pb/Gb, second-level carry lookahead across groups).
- Adds a valid/ready handshake, subtract mode, carry-in and status flags.
- Serves as the datapath arithmetic unit for the multi-cycle ALU; replaces the purely combinational 16-bit adder where timing requires registering.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of GROUP and at least GROUP.
- GROUP, 4, bits per lookahead group; the number of groups is NG = WIDTH/GROUP.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1; when sub=1, cout=1 means no borrow (A>=B unsigned).
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Clears both stage valid bits, sum, cout, ovf and zero to 0.
  - in_ready = 1 in the cycle following reset.
  - rst overrides any handshake in the same cycle; in-flight beats are discarded, not delivered.
- Pipeline control:
  - adv = !out_valid | out_ready.
  - in_ready = adv (combinational).
  - When adv=1, stage 1 loads the input beat and stage 2 loads stage 1; otherwise both stages hold.
  - A beat is accepted when in_valid & in_ready.
  - When adv=1 and in_valid=0, stage 1 valid becomes 0 (bubble).
  - Bubbles propagate; no bubble collapsing is required.
- Latency:
  - A beat accepted at edge k appears at the outputs with out_valid=1 after edge k+2, given no stall.
  - Throughput is 1 beat per cycle while out_ready=1.
- Stage 1, registered at an accepting edge:
  - bb = sub ? ~b : b; c0 = sub ? 1 : cin.
  - Per-bit p = a^bb, g = a&bb.
  - Per group j: Pb_j = AND of its p bits; Gb_j = G[n-1] | P[n-1]G[n-2] | ... | P[n-1]..P[1]G[0].
  - Also registers p, g, c0, a[WIDTH-1] and bb[WIDTH-1].
- Stage 2, registered into the outputs:
  - Group carry-ins: C_0 = c0; C_(j+1) = Gb_j | Pb_j & C_j, computed in lookahead (flattened) form, not ripple.
  - Bit carries within each group are computed by lookahead from C_j.
  - sum[i] = p[i] ^ c[i].
  - cout = carry out of group NG-1.
  - ovf = (a_msb == bb_msb) & (sum[WIDTH-1] != a_msb).
  - zero = (sum == 0).
- Output hold:
  - While out_valid=1 and out_ready=0, sum, cout, ovf and zero stay stable and stage 1 holds.
  - Outputs are don't-care when out_valid=0 but must not be X after reset.
- Width rules: WIDTH not a multiple of GROUP is a compile-time error (generate-time check).
- sub=1 with cin=1 still computes A-B; cin is ignored.
- Wrap-around: results are modulo 2^WIDTH, with the carry reported via cout.
- Simultaneous events:
  - in_valid with out_valid & out_ready in the same cycle: accept and shift (full throughput).
  - rst with any of these: reset wins.

Test Plan (WIDTH=16, GROUP=4 unless noted):
- After reset, a=16'h1234, b=16'h4321, cin=0, sub=0 accepted at cycle 0 -> out_valid at cycle 2, sum=16'h5555, cout=0, ovf=0, zero=0.
- a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, zero=1, ovf=0. Then a=16'h7FFF, b=16'h0001 -> sum=16'h8000, ovf=1, cout=0.
- sub=1: a=16'h0005, b=16'h0007 (cin=1, ignored) -> sum=16'hFFFE, cout=0. Then a=16'h8000, b=16'h0001 -> sum=16'h7FFF, ovf=1, cout=1.
- Stream 5 back-to-back beats with out_ready held low for cycles 3-5 -> in_ready=0 during the stall, outputs frozen on beat 1; all 5 results delivered in order, none lost or duplicated.
- Assert rst in the cycle after two beats are accepted -> next cycle out_valid=0, all outputs 0, in_ready=1; neither beat is ever delivered.
- WIDTH=32, GROUP=8: random 10k beats with random sub/cin and random out_ready backpressure -> every result matches the reference model {cout,sum} = a + (sub?~b:b) + (sub?1:cin), with ovf and zero flags as specified.

Source files
------------

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// Stage 1 forms bit and group propagate/generate; stage 2 resolves carries and flags.
module cla_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_bad_width
    $error("cla_addsub_pipe: WIDTH must be a non-zero multiple of GROUP");
  end

  // Handshake: a beat moves on any edge where valid & ready are both high.
  // The whole pipe advances when the output slot is empty or being drained;
  // otherwise every stage holds, so in_ready is simply that advance condition.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- stage 1: propagate / generate ----------------
  logic [WIDTH-1:0] bb, p_c, g_c;
  logic             c0_c;
  logic [NG-1:0]    pb_c, gb_c;

  always_comb begin
    bb   = sub ? ~b : b;
    c0_c = sub ? 1'b1 : cin;
    p_c  = a ^ bb;
    g_c  = a & bb;
    pb_c = '0;
    gb_c = '0;
    for (int j = 0; j < NG; j++) begin
      logic term;
      term    = 1'b0;
      pb_c[j] = &p_c[j*GROUP +: GROUP];
      // Gb = G[n-1] | P[n-1]G[n-2] | ... | P[n-1]..P[1]G[0]
      for (int m = 0; m < GROUP; m++) begin
        term = g_c[j*GROUP + m];
        for (int q = m + 1; q < GROUP; q++) term = term & p_c[j*GROUP + q];
        gb_c[j] = gb_c[j] | term;
      end
    end
  end

  logic             s1_valid;
  logic [WIDTH-1:0] s1_p, s1_g;
  logic [NG-1:0]    s1_pb, s1_gb;
  logic             s1_c0, s1_amsb, s1_bmsb;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_pb    <= '0;
      s1_gb    <= '0;
      s1_c0    <= 1'b0;
      s1_amsb  <= 1'b0;
      s1_bmsb  <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_p     <= p_c;
      s1_g     <= g_c;
      s1_pb    <= pb_c;
      s1_gb    <= gb_c;
      s1_c0    <= c0_c;
      s1_amsb  <= a[WIDTH-1];
      s1_bmsb  <= bb[WIDTH-1];
    end
  end

  // ---------------- stage 2: carry resolution ----------------
  logic [NG:0]      gc;
  logic [WIDTH-1:0] bc, sum_c;
  logic             cout_c, ovf_c, zero_c;

  always_comb begin
    gc    = '0;
    bc    = '0;
    gc[0] = s1_c0;
    // Group carries in flattened form: every C_(j+1) sees c0 and all Gb directly.
    for (int j = 0; j < NG; j++) begin
      logic acc, t;
      acc = s1_c0;
      for (int q = 0; q <= j; q++) acc = acc & s1_pb[q];
      for (int k = 0; k <= j; k++) begin
        t = s1_gb[k];
        for (int q = k + 1; q <= j; q++) t = t & s1_pb[q];
        acc = acc | t;
      end
      gc[j+1] = acc;
    end
    for (int j = 0; j < NG; j++) begin
      for (int m = 0; m < GROUP; m++) begin
        logic acc, t;
        acc = gc[j];
        for (int q = 0; q < m; q++) acc = acc & s1_p[j*GROUP + q];
        for (int k = 0; k < m; k++) begin
          t = s1_g[j*GROUP + k];
          for (int q = k + 1; q < m; q++) t = t & s1_p[j*GROUP + q];
          acc = acc | t;
        end
        bc[j*GROUP + m] = acc;
      end
    end
    sum_c  = s1_p ^ bc;
    cout_c = gc[NG];
    ovf_c  = (s1_amsb == s1_bmsb) && (sum_c[WIDTH-1] != s1_amsb);
    zero_c = (sum_c == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      sum       <= sum_c;
      cout      <= cout_c;
      ovf       <= ovf_c;
      zero      <= zero_c;
    end
  end

endmodule
